cpu_run_controller: RTL
=======================

// Module: cpu_run_controller
// PURPOSE
//   Sequences one program run of the pipelined 9-bit-ISA core. Holds the core in init, releases
//   it, counts executed cycles, and on halt decode waits for the EX/MEM/WB stages to retire.
//   Then it raises done. It also aborts runaway programs with a timeout.
//   Sits above the CPU top level: drives its init/run controls and reads its halt-detect signal.
// PARAMETERS
//   INIT_CYCLES   2      cycles core_init is held high after start (>=1)
//   DRAIN_CYCLES  3      cycles after halt before done (EX, MEM, WB retire; >=1)
//   CNT_W         16     width of cycle counter
//   TIMEOUT       0      RUN-cycle limit; 0 disables timeout
// PORTS
//   clk           in   1      clock, all state on posedge
//   reset_n       in   1      asynchronous, active-low reset
//   start         in   1      level/pulse; sampled each cycle
//   halt_seen     in   1      IF/ID holds halt opcode 9'b111000000
//   core_init     out  1      drives CPU init/reset (active-high)
//   core_run      out  1      enables PC advance; low = fetch frozen
//   busy          out  1      high in INIT, RUN, DRAIN
//   done          out  1      high in DONE only
//   timeout       out  1      sticky: run ended by TIMEOUT, not halt
//   cycle_count   out  CNT_W  RUN cycles of the last/current run, saturating
// BEHAVIOUR
//   States: IDLE, INIT, RUN, DRAIN, DONE. Reset (reset_n=0, async) -> IDLE.
//     Counters cleared; core_init=1, core_run=0, busy=0, done=0, timeout=0, cycle_count=0.
//   IDLE:  core_init=1. start=1 -> INIT, clear cycle_count/timeout, load init counter.
//   INIT:  core_init=1, core_run=0. Stays exactly INIT_CYCLES cycles, then -> RUN.
//     halt_seen is ignored in INIT.
//   RUN:   core_init=0, core_run=1. cycle_count += 1 each RUN cycle; saturates at 2^CNT_W-1.
//     halt_seen=1 -> DRAIN, and the halt cycle is counted.
//     TIMEOUT!=0 and cycle_count==TIMEOUT-1 with no halt -> DRAIN with timeout<=1.
//     If halt and timeout occur in the same cycle, halt wins and timeout stays 0.
//   DRAIN: core_run=0 (fetch frozen, pipeline retires), core_init=0.
//     Stays exactly DRAIN_CYCLES cycles, then -> DONE. cycle_count is frozen.
//   DONE:  done=1, core_run=0, core_init=0; outputs held.
//     start=1 -> INIT (new run, done drops next cycle). Otherwise stays in DONE.
//   start in INIT/RUN/DRAIN is ignored; there is no restart mid-run.
//   Latency: start to the first RUN cycle = INIT_CYCLES+1 clocks.
//     halt_seen to done = DRAIN_CYCLES+1 clocks.
//   All outputs are registered (Moore); no combinational start->output path.
//   reset_n asserted mid-run -> immediate IDLE with reset values; the core is re-held in init.
// STRUCTURE
//   Defs package: typedef enum logic [2:0] RunState {RS_IDLE, RS_INIT, RS_RUN, RS_DRAIN, RS_DONE};
//   Defs package: localparam HALT_OPCODE = 9'b111000000.
//   Sub-module: run_cycle_counter (CNT_W, clear/enable inputs, saturating, async active-low reset).
//   Init and drain countdowns are a single shared down-counter in the FSM, sized to max(INIT, DRAIN).
// TESTING
//   1 Reset: reset_n=0 for 2 clk -> core_init=1, core_run=0, done=0, cycle_count=0, state IDLE.
//   2 Nominal: start pulse, halt_seen after 10 RUN cycles -> core_init high 2 clk.
//     Then cycle_count=10, done rises 4 clk after halt, timeout=0.
//   3 Timeout: TIMEOUT=20, halt_seen never -> DRAIN after 20 RUN cycles, timeout=1, done, count=20.
//   4 Tie: TIMEOUT=5, halt_seen on the 5th RUN cycle -> timeout=0, cycle_count=5.
//   5 Ignore/restart: start held through RUN -> no restart.
//     start in DONE -> done=0 next clk, INIT, count cleared.
//   6 Async reset mid-RUN at cycle 7 -> outputs reset without a clock edge; next start runs clean.
//   7 Saturation: CNT_W=4, halt after 20 cycles -> cycle_count=15.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the run controller that sequences one program run
// of the pipelined 9-bit-ISA core.
package cpu_run_controller_pkg;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_INIT,
        RS_RUN,
        RS_DRAIN,
        RS_DONE
    } RunState;

    // Opcode the core's IF/ID stage compares against to raise halt_seen.
    localparam logic [8:0] HALT_OPCODE = 9'b111000000;

    // Width of the shared init/drain down-counter; it only ever holds N-1.
    function automatic int downCntWidth(input int initCycles, input int drainCycles);
        int maxCycles;
        maxCycles = (initCycles > drainCycles) ? initCycles : drainCycles;
        return (maxCycles <= 2) ? 1 : $clog2(maxCycles);
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating count of RUN cycles; clear has priority over enable.
module run_cycle_counter
    import cpu_run_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Holds the core in init, releases it, counts RUN cycles, drains the pipe on
// halt (or timeout) and reports done. All outputs are registered.
module cpu_run_controller
    import cpu_run_controller_pkg::*;
#(
    parameter int unsigned INIT_CYCLES  = 2,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned TIMEOUT      = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt_seen,
    output logic             core_init,
    output logic             core_run,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DOWN_W = downCntWidth(int'(INIT_CYCLES), int'(DRAIN_CYCLES));
    localparam logic [DOWN_W-1:0] INIT_LOAD    = DOWN_W'(INIT_CYCLES - 1);
    localparam logic [DOWN_W-1:0] DRAIN_LOAD   = DOWN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    RunState           state;
    RunState           nextState;
    logic [DOWN_W-1:0] downCnt;
    logic [DOWN_W-1:0] downCntNext;
    logic              timeoutNext;
    logic              cntClear;
    logic              cntEnable;

    run_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_run_cycle_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cntClear),
        .enable  (cntEnable),
        .count   (cycle_count)
    );

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState   = state;
        downCntNext = downCnt;
        timeoutNext = timeout;
        cntClear    = 1'b0;
        cntEnable   = 1'b0;
        case (state)
            RS_IDLE, RS_DONE: begin
                if (start) begin
                    nextState   = RS_INIT;
                    downCntNext = INIT_LOAD;
                    timeoutNext = 1'b0;
                    cntClear    = 1'b1;
                end
            end
            RS_INIT: begin
                if (downCnt == '0) nextState = RS_RUN;
                else               downCntNext = downCnt - DOWN_W'(1);
            end
            RS_RUN: begin
                cntEnable = 1'b1;
                // Halt is checked first so a halt on the limit cycle is not a timeout.
                if (halt_seen) begin
                    nextState   = RS_DRAIN;
                    downCntNext = DRAIN_LOAD;
                end else if ((TIMEOUT != 0) && (cycle_count == TIMEOUT_LAST)) begin
                    nextState   = RS_DRAIN;
                    downCntNext = DRAIN_LOAD;
                    timeoutNext = 1'b1;
                end
            end
            RS_DRAIN: begin
                if (downCnt == '0) nextState = RS_DONE;
                else               downCntNext = downCnt - DOWN_W'(1);
            end
            default: nextState = RS_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change with the state flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RS_IDLE;
            downCnt   <= '0;
            timeout   <= 1'b0;
            core_init <= 1'b1;
            core_run  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nextState;
            downCnt   <= downCntNext;
            timeout   <= timeoutNext;
            core_init <= (nextState == RS_IDLE) || (nextState == RS_INIT);
            core_run  <= (nextState == RS_RUN);
            busy      <= (nextState == RS_INIT) || (nextState == RS_RUN) || (nextState == RS_DRAIN);
            done      <= (nextState == RS_DONE);
        end
    end

endmodule
